gl6_pixel_split: RTL and testbench

- Upstream neighbour of the 2x2 averaging stage. Takes one raster-order luma stream and splits it into four streams a/b/c/d.
- Stream roles: a = even row, even column; b = even row, odd column; c = odd row, even column; d = odd row, odd column.
- Each 2x2 block's four pixels are presented together at the heads of the four output streams.
- Even-row pixels are buffered in line FIFOs until the matching odd row arrives.

---
 rtl/gl6_pixel_split.sv | 188 ++++++++++++++++++
 tb/tb_gl6_pixel_split.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gl6_pixel_split.sv
// Raster luma splitter: routes each pixel into one of four 2x2-phase FIFOs (a/b/c/d).
// Optional macro GL6_PIXEL_SPLIT_ERR_CNT_EN adds a saturating odd-width/odd-height event counter.
module gl6_pixel_split_fifo #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic         o_full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            // Clear wins over any pop; a same-cycle push becomes the sole entry.
            r_rd_ptr <= '0;
            r_wr_ptr <= AW'(i_push);
            r_count  <= (AW+1)'(i_push);
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[i_clr ? '0 : r_wr_ptr] <= i_din;
    end
endmodule

module gl6_pixel_split #(
    parameter int D_WIDTH    = 8,
    parameter int LINE_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data_a,
    output logic               down_valid_a,
    output logic               down_tlast_a,
    output logic               down_tuser_a,
    input  logic               down_ready_a,
    output logic [D_WIDTH-1:0] down_data_b,
    output logic               down_valid_b,
    output logic               down_tlast_b,
    output logic               down_tuser_b,
    input  logic               down_ready_b,
    output logic [D_WIDTH-1:0] down_data_c,
    output logic               down_valid_c,
    output logic               down_tlast_c,
    output logic               down_tuser_c,
    input  logic               down_ready_c,
    output logic [D_WIDTH-1:0] down_data_d,
    output logic               down_valid_d,
    output logic               down_tlast_d,
    output logic               down_tuser_d,
    input  logic               down_ready_d
`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
    ,
    output logic [15:0]        err_cnt
`endif
);
    localparam int AW = $clog2(LINE_DEPTH);
    localparam int EW = D_WIDTH + 2;

    logic          r_row;
    logic          r_col;
    logic          w_row_eff;
    logic          w_col_eff;
    logic          w_odd;
    logic          w_flush_case;
    logic          w_flush_stall;
    logic          w_accept;
    logic          w_clr_ab;
    logic [3:0]    w_tgt;
    logic [3:0]    w_push;
    logic [3:0]    w_clr;
    logic [3:0]    w_ready_dn;
    logic [3:0]    w_valid;
    logic [3:0]    w_full;
    logic [EW-1:0] w_din;
    logic [EW-1:0] w_dout [4];

    // A frame start always restarts the 2x2 phase at row 0 / col 0.
    assign w_row_eff = ~up_tuser & r_row;
    assign w_col_eff = ~up_tuser & r_col;
    assign w_odd     = up_tlast & ~w_col_eff;

    assign w_tgt[0] = ~w_row_eff & ~w_col_eff;
    assign w_tgt[1] = ~w_row_eff & (w_col_eff | w_odd);
    assign w_tgt[2] =  w_row_eff & ~w_col_eff;
    assign w_tgt[3] =  w_row_eff & (w_col_eff | w_odd);

    // New frame after an unpaired even row: let C/D drain, then drop the orphan row in A/B.
    assign w_flush_case  = up_valid & up_tuser & r_row;
    assign w_flush_stall = w_flush_case & (w_valid[2] | w_valid[3]);

    assign up_ready   = ~rst & ~(|(w_tgt & w_full)) & ~w_flush_stall;
    assign w_accept   = up_valid & up_ready;
    assign w_clr_ab   = w_accept & w_flush_case;
    assign w_push     = {4{w_accept}} & w_tgt;
    assign w_clr      = {2'b00, w_clr_ab, w_clr_ab};
    assign w_din      = {up_tuser, up_tlast, up_data};
    assign w_ready_dn = {down_ready_d, down_ready_c, down_ready_b, down_ready_a};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= 1'b0;
            r_col <= 1'b0;
        end else if (w_accept) begin
            r_row <= up_tlast ? ~w_row_eff : w_row_eff;
            r_col <= up_tlast ? 1'b0 : ~w_col_eff;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            gl6_pixel_split_fifo #(
                .W  (EW),
                .AW (gi < 2 ? AW : 2)
            ) u_fifo (
                .clk     (clk),
                .i_rst   (rst),
                .i_clr   (w_clr[gi]),
                .i_push  (w_push[gi]),
                .i_din   (w_din),
                .i_pop   (w_ready_dn[gi]),
                .o_dout  (w_dout[gi]),
                .o_valid (w_valid[gi]),
                .o_full  (w_full[gi])
            );
        end
    endgenerate

    assign {down_tuser_a, down_tlast_a, down_data_a} = w_dout[0];
    assign {down_tuser_b, down_tlast_b, down_data_b} = w_dout[1];
    assign {down_tuser_c, down_tlast_c, down_data_c} = w_dout[2];
    assign {down_tuser_d, down_tlast_d, down_data_d} = w_dout[3];
    assign down_valid_a = w_valid[0];
    assign down_valid_b = w_valid[1];
    assign down_valid_c = w_valid[2];
    assign down_valid_d = w_valid[3];

`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, w_accept & w_odd} + {1'b0, w_clr_ab};
    assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_err_inc);
    assign err_cnt   = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_err_cnt <= '0;
        else     r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_gl6_pixel_split.sv
// Randomized bench for gl6_pixel_split: queue-based model of the four output streams,
// compared every cycle, plus hand-computed head values from small directed frames.
module tb_gl6_pixel_split;
    localparam int DW = 8;
    localparam int LD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] up_data;
    logic          up_valid, up_tlast, up_tuser, up_ready;
    logic [DW-1:0] down_data_a, down_data_b, down_data_c, down_data_d;
    logic          down_valid_a, down_valid_b, down_valid_c, down_valid_d;
    logic          down_tlast_a, down_tlast_b, down_tlast_c, down_tlast_d;
    logic          down_tuser_a, down_tuser_b, down_tuser_c, down_tuser_d;
    logic          down_ready_a, down_ready_b, down_ready_c, down_ready_d;
`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    gl6_pixel_split #(.D_WIDTH(DW), .LINE_DEPTH(LD)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
        .up_ready(up_ready),
        .down_data_a(down_data_a), .down_valid_a(down_valid_a), .down_tlast_a(down_tlast_a),
        .down_tuser_a(down_tuser_a), .down_ready_a(down_ready_a),
        .down_data_b(down_data_b), .down_valid_b(down_valid_b), .down_tlast_b(down_tlast_b),
        .down_tuser_b(down_tuser_b), .down_ready_b(down_ready_b),
        .down_data_c(down_data_c), .down_valid_c(down_valid_c), .down_tlast_c(down_tlast_c),
        .down_tuser_c(down_tuser_c), .down_ready_c(down_ready_c),
        .down_data_d(down_data_d), .down_valid_d(down_valid_d), .down_tlast_d(down_tlast_d),
        .down_tuser_d(down_tuser_d), .down_ready_d(down_ready_d)
`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] head(input int i);
        case (i)
            0:       return {down_tuser_a, down_tlast_a, down_data_a};
            1:       return {down_tuser_b, down_tlast_b, down_data_b};
            2:       return {down_tuser_c, down_tlast_c, down_data_c};
            default: return {down_tuser_d, down_tlast_d, down_data_d};
        endcase
    endfunction

    function automatic logic vld(input int i);
        case (i)
            0:       return down_valid_a;
            1:       return down_valid_b;
            2:       return down_valid_c;
            default: return down_valid_d;
        endcase
    endfunction

    // Model: stream index = 2*row + col; queues hold {tuser,tlast,data}.
    logic [9:0] mq [4][$];
    int         m_row = 0;
    int         m_col = 0;
    int         m_err = 0;
    bit         m_acc = 0;
    string      sn = "abcd";

    always @(negedge clk) begin
        int  re, ce, idx, cap;
        bit  odd, fc, stall, rdy, blocked;
        bit  pop_rq [4];
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid_%s", sn.substr(i, i)), {31'd0, vld(i)}, {31'd0, mq[i].size() != 0});
            chk($sformatf("head_%s", sn.substr(i, i)), {22'd0, head(i)},
                {22'd0, (mq[i].size() != 0) ? mq[i][0] : 10'd0});
        end
`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
        chk("err_cnt", {16'd0, err_cnt}, m_err);
`endif
        re  = up_tuser ? 0 : m_row;
        ce  = up_tuser ? 0 : m_col;
        odd = up_tlast && (ce == 0);
        idx = 2 * re + ce;
        fc  = up_valid && up_tuser && (m_row == 1);
        stall = fc && (mq[2].size() != 0 || mq[3].size() != 0);
        cap = (idx < 2) ? LD : 4;
        blocked = (mq[idx].size() == cap) || (odd && mq[idx + 1].size() == cap);
        rdy = !rst && !stall && !blocked;
        chk("up_ready", {31'd0, up_ready}, {31'd0, rdy});
        pop_rq[0] = down_ready_a; pop_rq[1] = down_ready_b;
        pop_rq[2] = down_ready_c; pop_rq[3] = down_ready_d;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_row = 0; m_col = 0; m_err = 0; m_acc = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0 && pop_rq[i]) void'(mq[i].pop_front());
            m_acc = up_valid && rdy;
            if (m_acc) begin
                if (fc) begin
                    mq[0].delete(); mq[1].delete();
                    m_err++;
                end
                mq[idx].push_back({up_tuser, up_tlast, up_data});
                if (odd) begin
                    mq[idx + 1].push_back({up_tuser, up_tlast, up_data});
                    m_err++;
                end
                if (m_err > 65535) m_err = 65535;
                if (up_tlast) begin m_row = 1 - re; m_col = 0; end
                else          begin m_row = re;     m_col = 1 - ce; end
            end
        end
    end

    bit rand_rdy = 0;
    bit acc_seen = 0;

    task automatic set_rdy(input logic [3:0] m);
        {down_ready_d, down_ready_c, down_ready_b, down_ready_a} = m;
    endtask

    task automatic tick();
        @(posedge clk);
        acc_seen = m_acc;
        #1;
        if (rand_rdy) set_rdy(4'($urandom_range(0, 15) | $urandom_range(0, 15)));
    endtask

    task automatic send(input logic [7:0] d, input bit l, input bit u);
        tick();
        up_data = d; up_tlast = l; up_tuser = u; up_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            tick();
            if (acc_seen) begin
                up_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
        up_valid = 1'b0;
    endtask

    task automatic pop_once(input logic [3:0] m);
        tick(); set_rdy(m);
        tick(); set_rdy(4'h0);
    endtask

    task automatic drain();
        rand_rdy = 0;
        tick(); set_rdy(4'hF);
        repeat (15) tick();
        set_rdy(4'h0);
    endtask

    task automatic chk_heads(input string nm, input logic [9:0] a, input logic [9:0] b,
                             input logic [9:0] c, input logic [9:0] d);
        @(negedge clk);
        chk({nm, "_a"}, {22'd0, head(0)}, {22'd0, a});
        chk({nm, "_b"}, {22'd0, head(1)}, {22'd0, b});
        chk({nm, "_c"}, {22'd0, head(2)}, {22'd0, c});
        chk({nm, "_d"}, {22'd0, head(3)}, {22'd0, d});
    endtask

    initial begin
        rst = 1'b1; up_data = '0; up_valid = 0; up_tlast = 0; up_tuser = 0;
        set_rdy(4'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("lit_rst_ready", {31'd0, up_ready}, 32'd0);
        chk("lit_rst_valid_a", {31'd0, down_valid_a}, 32'd0);
        tick(); rst = 1'b0;

        // Three rows of width 2 followed by a new frame: flush of the orphan row.
        send(1, 0, 1); send(2, 1, 0); send(3, 0, 0); send(4, 1, 0); send(5, 0, 0); send(6, 1, 0);
        chk_heads("lit_h3", 10'h201, 10'h102, 10'h003, 10'h104);
        tick(); up_data = 99; up_tuser = 1; up_tlast = 0; up_valid = 1;
        tick(); tick();
        @(negedge clk);
        chk("lit_flush_stall", {31'd0, up_ready}, 32'd0);
        pop_once(4'hF);
        for (int t = 0; t < 20; t++) begin
            tick();
            if (acc_seen) break;
        end
        up_valid = 0;
        @(negedge clk);
        chk("lit_flush_a", {22'd0, head(0)}, 32'h263);
        chk("lit_flush_b_empty", {31'd0, down_valid_b}, 32'd0);
`ifdef GL6_PIXEL_SPLIT_ERR_CNT_EN
        chk("lit_err_cnt", {16'd0, err_cnt}, 32'd1);
`endif
        drain();

        // 4x2 frame held back, then released block by block.
        for (int p = 0; p < 8; p++) send(8'(p), (p == 3 || p == 7), p == 0);
        chk_heads("lit_4x2_blk0", 10'h200, 10'h001, 10'h004, 10'h005);
        pop_once(4'hF);
        chk_heads("lit_4x2_blk1", 10'h002, 10'h103, 10'h006, 10'h107);
        drain();

        // Width-3 line pair: last column duplicated into both streams of the pair.
        send(10, 0, 1); send(11, 0, 0); send(12, 1, 0);
        send(20, 0, 0); send(21, 0, 0); send(22, 1, 0);
        chk_heads("lit_w3_blk0", 10'h20A, 10'h00B, 10'h014, 10'h015);
        pop_once(4'hF);
        chk_heads("lit_w3_blk1", 10'h10C, 10'h10C, 10'h116, 10'h116);
        drain();

        // Line of 8 fills A and B; the odd row is still accepted.
        for (int p = 0; p < 8; p++) send(8'(p), p == 7, p == 0);
        tick(); up_data = 8; up_tuser = 0; up_tlast = 0; up_valid = 1;
        @(negedge clk);
        chk("lit_full_ab_odd_ready", {31'd0, up_ready}, 32'd1);
        tick(); up_valid = 0;
        set_rdy(4'hF);
        for (int p = 9; p < 16; p++) send(8'(p), p == 15, 0);
        drain();

        // Reset in the middle of row 1.
        for (int p = 0; p < 5; p++) send(8'(p), p == 3, p == 0);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("lit_midrst_ready", {31'd0, up_ready}, 32'd0);
        tick(); rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("lit_midrst_valid", {31'd0, vld(i)}, 32'd0);
        send(42, 0, 0);
        @(negedge clk);
        chk("lit_midrst_a", {22'd0, head(0)}, 32'h02A);
        chk("lit_midrst_b_empty", {31'd0, down_valid_b}, 32'd0);
        drain();

        // Random frames with random per-stream back-pressure.
        rand_rdy = 1;
        for (int f = 0; f < 14; f++) begin
            int w, h;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 5);
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    send(8'($urandom_range(0, 255)), c == w - 1, (r == 0) && (c == 0));
                    if ($urandom_range(0, 3) == 0) tick();
                end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
